// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 8-digit LED scan controller.
// Holds the scan state encoding, digit count, segment bit positions and hex glyph table.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Index 0 is the last element of the concatenation: glyphs for 0..F, segments a..g in bits 0..6.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to seven-segment glyph; purely combinational, no latency, no flow control.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scanner with frame-aligned double buffering, dead-time blanking and 4-bit PWM.
// Outputs registered (one edge after the state decision); LOAD is never refused, latest write wins.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int ON_SHIFT     = 6,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  LOAD,
    input  logic [31:0]           DATA,
    input  logic [7:0]            DP,
    input  logic [3:0]            BRIGHT,
    output logic                  ACK,
    output logic                  PENDING,
    output logic                  FRAME,
    output logic [NUM_DIGITS-1:0] drains,
    output logic [7:0]            leds
);

    localparam int              CW         = ON_SHIFT + 4;
    localparam logic [CW-1:0]   SLOT_LAST  = '1;
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [7:0]      BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_t               state, state_nx;
    logic [DIGIT_W-1:0]   digit, digit_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [7:0]           bcnt, bcnt_nx;
    logic [3:0]           bri, bri_nx;
    logic [31:0]          act_dat, act_dat_nx, shd_dat, shd_dat_nx;
    logic [7:0]           act_dp, act_dp_nx, shd_dp, shd_dp_nx;
    logic                 pend, pend_nx;
    logic                 frame_start, commit;

    logic [NUM_DIGITS-1:0] drains_nx;
    logic [7:0]            leds_nx;
    logic                  lit;
    logic [CW:0]           lit_len;
    logic [3:0]            nib;
    logic [6:0]            seg;

    assign PENDING = pend;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            digit   <= '0;
            cnt     <= '0;
            bcnt    <= '0;
            bri     <= '0;
            act_dat <= '0;
            act_dp  <= '0;
            shd_dat <= '0;
            shd_dp  <= '0;
            pend    <= 1'b0;
            drains  <= '0;
            leds    <= '0;
            ACK     <= 1'b0;
            FRAME   <= 1'b0;
        end else begin
            state   <= state_nx;
            digit   <= digit_nx;
            cnt     <= cnt_nx;
            bcnt    <= bcnt_nx;
            bri     <= bri_nx;
            act_dat <= act_dat_nx;
            act_dp  <= act_dp_nx;
            shd_dat <= shd_dat_nx;
            shd_dp  <= shd_dp_nx;
            pend    <= pend_nx;
            drains  <= drains_nx;
            leds    <= leds_nx;
            ACK     <= commit;
            FRAME   <= frame_start;
        end
    end

    always_comb begin
        state_nx    = state;
        digit_nx    = digit;
        cnt_nx      = cnt;
        bcnt_nx     = bcnt;
        bri_nx      = bri;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (EN) begin
                    state_nx    = ST_BLANK;
                    digit_nx    = '0;
                    bcnt_nx     = '0;
                    frame_start = 1'b1;
                end
            end
            ST_BLANK: begin
                if (bcnt == BLANK_LAST) begin
                    state_nx = ST_ON;
                    cnt_nx   = '0;
                    bri_nx   = BRIGHT;
                end else begin
                    bcnt_nx = bcnt + 8'd1;
                end
            end
            ST_ON: begin
                cnt_nx = cnt + CNT_ONE;
                if (cnt == SLOT_LAST) begin
                    state_nx    = ST_BLANK;
                    bcnt_nx     = '0;
                    digit_nx    = digit + DIGIT_W'(1);
                    frame_start = (digit == DIGIT_W'(NUM_DIGITS - 1));
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // Disable overrides everything; the shadow and its pending flag survive.
        if (!EN) begin
            state_nx    = ST_IDLE;
            digit_nx    = '0;
            frame_start = 1'b0;
        end

        commit     = frame_start && pend;
        act_dat_nx = commit ? shd_dat : act_dat;
        act_dp_nx  = commit ? shd_dp  : act_dp;
        shd_dat_nx = LOAD ? DATA : shd_dat;
        shd_dp_nx  = LOAD ? DP   : shd_dp;
        pend_nx    = LOAD ? 1'b1 : (commit ? 1'b0 : pend);
    end

    assign nib = act_dat_nx[{digit_nx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nib),
        .seg    (seg)
    );

    // Outputs are decoded from next-state values so the registered pins line up with the state.
    always_comb begin
        lit_len   = {{(CW-3){1'b0}}, bri_nx} << ON_SHIFT;
        lit       = (state_nx == ST_ON) && ({1'b0, cnt_nx} < lit_len);
        drains_nx = '0;
        leds_nx   = '0;
        if (lit) begin
            drains_nx               = NUM_DIGITS'(1) << digit_nx;
            leds_nx[SEG_G:SEG_A]    = seg;
            leds_nx[SEG_DP]         = act_dp_nx[digit_nx];
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench: arithmetic frame-position reference model plus vector table and corner sequences.
module tb_disp_scan_ctrl;

    localparam int ON_SHIFT     = 2;
    localparam int BLANK_CYCLES = 4;
    localparam int PER          = BLANK_CYCLES + (16 << ON_SHIFT);
    localparam int FRAME_LEN    = 8 * PER;

    logic        CLK = 1'b0;
    logic        RESET, EN, LOAD;
    logic [31:0] DATA;
    logic [7:0]  DP;
    logic [3:0]  BRIGHT;
    logic        ACK, PENDING, FRAME;
    logic [7:0]  drains, leds;

    disp_scan_ctrl #(.ON_SHIFT(ON_SHIFT), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .DATA(DATA), .DP(DP),
        .BRIGHT(BRIGHT), .ACK(ACK), .PENDING(PENDING), .FRAME(FRAME),
        .drains(drains), .leds(leds)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: position within the frame decides everything.
    bit          m_run = 0;
    int          m_pos = 0;
    int          m_b   = 0;
    int          m_d, m_w;
    bit          m_pend = 0, m_fs, m_lit;
    logic [31:0] m_act = 0, m_shd = 0;
    logic [7:0]  m_actdp = 0, m_shddp = 0;
    logic [7:0]  e_drains = 0, e_leds = 0;
    logic        e_frame = 0, e_ack = 0;

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            m_run = 0; m_pos = 0; m_pend = 0;
            m_act = 0; m_shd = 0; m_actdp = 0; m_shddp = 0;
            e_frame = 0; e_ack = 0; e_drains = 0; e_leds = 0;
        end else begin
            m_fs = 0;
            e_drains = 0;
            e_leds = 0;
            if (EN) begin
                if (!m_run) begin
                    m_run = 1; m_pos = 0; m_fs = 1;
                end else begin
                    m_pos = (m_pos + 1) % FRAME_LEN;
                    m_fs = (m_pos == 0);
                end
            end else begin
                m_run = 0;
            end
            e_frame = m_fs;
            e_ack = m_fs && m_pend;
            if (e_ack) begin
                m_act = m_shd; m_actdp = m_shddp;
            end
            if (LOAD) begin
                m_shd = DATA; m_shddp = DP; m_pend = 1;
            end else if (e_ack) begin
                m_pend = 0;
            end
            if (m_run) begin
                m_d = m_pos / PER;
                m_w = m_pos % PER;
                if (m_w == BLANK_CYCLES) m_b = BRIGHT;
                m_lit = (m_w >= BLANK_CYCLES) && ((m_w - BLANK_CYCLES) < m_b * (1 << ON_SHIFT));
                if (m_lit) begin
                    e_drains = 8'(1 << m_d);
                    e_leds = {m_actdp[m_d], seg_ref[m_act[4*m_d +: 4]]};
                end
            end
        end
        #1;
        check("model_drains", drains, e_drains);
        check("model_leds", leds, e_leds);
        check("model_frame", FRAME, e_frame);
        check("model_ack", ACK, e_ack);
        check("model_pending", PENDING, m_pend);
    end

    typedef struct {
        logic [31:0]     data;
        logic [7:0]      dp;
        logic [3:0]      bright;
        logic [7:0][7:0] exp_leds;
        int              exp_lit;
    } vec_t;

    vec_t vecs [4];

    task automatic wait_frame(input int limit, input string tag);
        int n = 0;
        while (FRAME !== 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check(tag, FRAME, 1);
    endtask

    task automatic wait_ack(input int limit, input string tag);
        int n = 0;
        while (ACK !== 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check(tag, ACK, 1);
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] p);
        DATA = d; DP = p; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    // Called on a frame-start cycle; observes one whole frame.
    task automatic measure_frame(input logic [7:0][7:0] exp, input int exp_lit, input string tag);
        int cnt [8];
        int first [8];
        int last [8];
        int bad [8];
        int nonhot = 0;
        for (int d = 0; d < 8; d++) begin
            cnt[d] = 0; first[d] = 0; last[d] = 0; bad[d] = 0;
        end
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (drains != 8'h00) begin
                if (!$onehot(drains)) nonhot++;
                for (int d = 0; d < 8; d++) begin
                    if (drains[d]) begin
                        if (cnt[d] == 0) first[d] = k;
                        last[d] = k;
                        cnt[d]++;
                        if (leds !== exp[d]) bad[d]++;
                    end
                end
            end
            @(negedge CLK);
        end
        check({tag, "_onehot"}, nonhot, 0);
        for (int d = 0; d < 8; d++) begin
            check($sformatf("%s_lit%0d", tag, d), cnt[d], exp_lit);
            check($sformatf("%s_leds%0d", tag, d), bad[d], 0);
            if (cnt[d] > 0) check($sformatf("%s_contig%0d", tag, d), last[d] - first[d] + 1, cnt[d]);
        end
    endtask

    int t_frame, t_drv, n;

    initial begin
        vecs[0] = '{32'h76543210, 8'h00, 4'd15,
                    {8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F}, 60};
        vecs[1] = '{32'hFEDCBA98, 8'hA5, 4'd8,
                    {8'hF1, 8'h79, 8'hDE, 8'h39, 8'h7C, 8'hF7, 8'h6F, 8'hFF}, 32};
        vecs[2] = '{32'h000000F8, 8'h01, 4'd15,
                    {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h71, 8'hFF}, 60};
        vecs[3] = '{32'h00000000, 8'hFF, 4'd0,
                    {8{8'hBF}}, 0};

        RESET = 1'b1; EN = 1'b1; LOAD = 1'b0; DATA = '0; DP = '0; BRIGHT = 4'd15;
        repeat (3) @(negedge CLK);
        check("rst_drains", drains, 0);
        check("rst_leds", leds, 0);
        check("rst_frame", FRAME, 0);
        check("rst_pending", PENDING, 0);

        // Reset release: frame on the first cycle, digit 0 after the blank, fixed frame period.
        RESET = 1'b0;
        @(negedge CLK);
        check("first_frame", FRAME, 1);
        t_frame = cyc;
        n = 0;
        while (drains !== 8'h01 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("frame_to_drains", cyc - t_frame, BLANK_CYCLES);
        @(negedge CLK);
        wait_frame(2 * FRAME_LEN, "second_frame");
        check("frame_period", cyc - t_frame, FRAME_LEN);

        // Vector table: load, expect ACK with FRAME, then check the following frame.
        for (int i = 0; i < 4; i++) begin
            BRIGHT = vecs[i].bright;
            pulse_load(vecs[i].data, vecs[i].dp);
            check($sformatf("vec%0d_pending", i), PENDING, 1);
            wait_ack(2 * FRAME_LEN, $sformatf("vec%0d_ack", i));
            check($sformatf("vec%0d_ack_frame", i), FRAME, 1);
            check($sformatf("vec%0d_ack_pend", i), PENDING, 0);
            measure_frame(vecs[i].exp_leds, vecs[i].exp_lit, $sformatf("vec%0d", i));
        end

        // Two loads in one frame: one ACK, latest value shown.
        BRIGHT = 4'd15;
        wait_frame(2 * FRAME_LEN, "dbl_sync");
        pulse_load(32'h11111111, 8'h00);
        repeat (10) @(negedge CLK);
        pulse_load(32'h22222222, 8'h00);
        wait_ack(2 * FRAME_LEN, "dbl_ack");
        check("dbl_pend", PENDING, 0);
        measure_frame({8{8'h5B}}, 60, "dbl");
        check("dbl_no_second_ack", ACK, 0);

        // LOAD on the commit edge: old shadow committed, new one stays pending.
        wait_frame(2 * FRAME_LEN, "cc_sync");
        repeat (100) @(negedge CLK);
        pulse_load(32'h33333333, 8'h00);
        repeat (FRAME_LEN - 102) @(negedge CLK);
        DATA = 32'h44444444; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        check("cc_frame", FRAME, 1);
        check("cc_ack", ACK, 1);
        check("cc_pend", PENDING, 1);
        measure_frame({8{8'h4F}}, 60, "cc_old");
        check("cc_ack2", ACK, 1);
        check("cc_pend2", PENDING, 0);
        measure_frame({8{8'h66}}, 60, "cc_new");

        // EN dropped while digit 5 is lit, then restarted.
        n = 0;
        while (drains !== 8'h20 && n < 2 * FRAME_LEN) begin
            @(negedge CLK);
            n++;
        end
        check("en_digit5", drains, 8'h20);
        EN = 1'b0;
        @(negedge CLK);
        check("en_off_drains", drains, 0);
        check("en_off_leds", leds, 0);
        EN = 1'b1;
        @(negedge CLK);
        check("en_restart_frame", FRAME, 1);
        t_drv = cyc;
        repeat (BLANK_CYCLES - 1) @(negedge CLK);
        check("en_restart_blank", drains, 0);
        @(negedge CLK);
        check("en_restart_drains", drains, 8'h01);
        check("en_restart_delay", cyc - t_drv, BLANK_CYCLES);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 8000; i++) begin
            RESET  = ($urandom_range(0, 2999) == 0);
            EN     = ($urandom_range(0, 599) != 0);
            LOAD   = ($urandom_range(0, 149) == 0);
            DATA   = $urandom;
            DP     = 8'($urandom);
            if ($urandom_range(0, 99) == 0) BRIGHT = 4'($urandom);
            @(negedge CLK);
        end
        RESET = 1'b0; LOAD = 1'b0; EN = 1'b1;
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan controller for the 8-digit multiplexed LED display: 8 low-side digit drains and 8 segment lines (7 segments + dp).
- Accepts a 32-bit hex value through a load/ack handshake and double-buffers it.
- Commits the buffered value only at frame boundaries, so no frame shows a mix of old and new digits.
- Sequences digits with dead-time blanking and 4-bit PWM brightness.
- Sits between the value producers (LFSR, counters) and the display pins.

Parameters:
- ON_SHIFT, 6: digit slot = 16<<ON_SHIFT cycles; PWM step = 1<<ON_SHIFT cycles.
- BLANK_CYCLES, 16: all-off dead time before each digit slot; legal range 1..255.

Ports:
- CLK  in  1  single system clock, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  scan enable.
- LOAD  in  1  one-cycle request to write DATA/DP into the shadow buffer.
- DATA  in  32  eight hex nibbles; nibble i goes to digit i.
- DP  in  8  decimal point per digit.
- BRIGHT  in  4  duty in sixteenths; 0 = dark.
- ACK  out  1  one-cycle pulse when the shadow buffer is committed to the active buffer.
- PENDING  out  1  shadow holds data not yet committed.
- FRAME  out  1  one-cycle pulse at each frame start (digit 0).
- drains  out  8  one-hot digit select, active-high; bit i = digit i.
- leds  out  8  segments a..g in bits 0..6, dp in bit 7, active-high.

Behaviour:
- Reset (sync, RESET=1 at a posedge):
  - State IDLE, digit=0, counters=0.
  - Active and shadow buffers = 0; PENDING=0.
  - drains, leds, ACK, FRAME = 0.
  - RESET has priority over all inputs.
- State machine IDLE -> BLANK -> ON -> BLANK -> ...
  - IDLE: outputs off. EN=1 moves to BLANK with digit=0; this counts as a frame start.
  - BLANK: drains=0, leds=0 for exactly BLANK_CYCLES cycles, then ON.
  - ON: lasts exactly 16<<ON_SHIFT cycles. BRIGHT is sampled on the ON entry cycle and held as B for the slot.
    - drains = one-hot(digit) and leds = seg(active nibble) | dp<<7 for the first B<<ON_SHIFT cycles.
    - drains and leds are 0 for the rest of the slot.
    - Then digit increments, wrapping 7 -> 0, and the state returns to BLANK.
- Frame start = entry into BLANK with digit=0 (from IDLE or from the wrap).
  - FRAME=1 for the first BLANK cycle.
  - If PENDING, active <= shadow on that same entry edge, ACK=1 for the same cycle as FRAME, and PENDING clears.
- LOAD:
  - Writes shadow and sets PENDING in any state, including IDLE.
  - A second LOAD before commit overwrites the shadow (latest wins); only one ACK is issued.
  - LOAD in the same cycle as a commit: the commit takes the old shadow value, the new data goes into the shadow, and PENDING stays 1.
- EN=0 in any state:
  - Next edge goes to IDLE; drains and leds are 0 from that edge.
  - digit resets to 0; shadow and PENDING are retained.
  - The next EN=1 starts a new frame.
- All outputs are registered. drains is never nonzero during BLANK or IDLE, and never has more than one bit set.
- Segment code (hex digit -> leds[6:0]):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Counters:
  - Slot counter is (ON_SHIFT+4) bits wide and wraps naturally.
  - Blank counter is 8 bits wide.
  - No other arithmetic overflow is possible.

Decomposition:
- Package disp_pkg:
  - State encoding (IDLE, BLANK, ON).
  - NUM_DIGITS=8.
  - Segment bit positions.
  - The 16-entry hex-to-segment constant table.
- Sub-module hex7seg: combinational 4-bit nibble -> 7-bit segments, instantiated once and fed by the active nibble selected by digit.

Test Plan (ON_SHIFT=2, BLANK_CYCLES=4; slot 64 cycles, frame 8*(4+64)=544 cycles):
1. Reset with EN=1: drains=0 and leds=0 during reset. First FRAME on the first cycle after reset release. drains=01 first appears 4 cycles later, and FRAME period is 544.
2. LOAD DATA=0x0000_00F8, DP=0x01, BRIGHT=15 while scanning:
   - ACK coincides with the next FRAME.
   - Digit 0 shows leds=FF (8 + dp) for 60 of its 64 cycles.
   - Digit 1 shows leds=71.
   - Digits 2..7 show 3F.
3. BRIGHT=0: drains stays 0 for a whole frame. BRIGHT=8: each digit is lit exactly 32 consecutive cycles per slot.
4. Two LOADs (0x11111111, then 0x22222222) within one frame: a single ACK, PENDING clears, and all digits show 5B.
5. LOAD asserted on the commit cycle: ACK=1, PENDING remains 1, the new value is committed at the following FRAME with a second ACK.
6. EN dropped mid-slot on digit 5: outputs are 0 on the next edge. Re-enabling gives FRAME on the next edge, and digit 0 drives drains=01 four cycles later.
